ecc_data_encoding: RTL

Write-side SECDED encoder for the ECC sync FIFO. It accepts 32-bit write data over a valid/ready handshake, computes 6 Hamming parity bits and 1 overall parity bit, and emits a registered 39-bit memory word. The word layout is {parity[6:0], data[31:0]}, which is the layout the read-side decoder consumes. It includes a 2-entry skid buffer so `wr_ready_o` is registered, plus a one-shot error-injection facility for ECC verification.

---
 rtl/ecc_pkg.sv | 80 ++++++++
 rtl/ecc_data_encoding_hamming_parity_gen.sv | 28 ++
 rtl/ecc_data_encoding.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED constants, types and codeword/memory bit mapping
// for the ECC sync FIFO encoder and decoder.
package ecc_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int PARITY_BITS       = 6;
    localparam int MEMORY_DATA_WIDTH = DATA_WIDTH + PARITY_BITS + 1;
    localparam int INJ_BIT_WIDTH     = 6;
    localparam int COUNT_WIDTH       = 16;
    localparam int MAX_INJ_BIT       = 38;

    typedef logic [DATA_WIDTH-1:0]        data_t;
    typedef logic [PARITY_BITS:0]         parity_t;
    typedef logic [MEMORY_DATA_WIDTH-1:0] mem_word_t;
    typedef logic [INJ_BIT_WIDTH-1:0]     inj_bit_t;
    typedef logic [COUNT_WIDTH-1:0]       count_t;

    typedef enum logic {
        INJ_SBE = 1'b0,
        INJ_DBE = 1'b1
    } inj_mode_e;

    typedef struct packed {
        logic      valid;
        mem_word_t word;
    } slot_t;

    typedef struct packed {
        logic      pending;
        inj_mode_e mode;
        inj_bit_t  bit_idx;
    } inj_t;

    // Codeword position of each data bit; powers of two and 0 are parity.
    localparam int DATA_POS [DATA_WIDTH] = '{
        3,  5,  6,  7,
        9,  10, 11, 12, 13, 14, 15,
        17, 18, 19, 20, 21, 22, 23, 24,
        25, 26, 27, 28, 29, 30, 31,
        33, 34, 35, 36, 37, 38
    };

    function automatic int mem_to_pos(input int bit_idx);
        if (bit_idx < DATA_WIDTH) begin
            return DATA_POS[bit_idx];
        end
        if (bit_idx == DATA_WIDTH) begin
            return 0;
        end
        return 1 << (bit_idx - DATA_WIDTH - 1);
    endfunction

    function automatic int pos_to_mem(input int pos);
        int idx;
        idx = 0;
        if (pos == 0) begin
            return DATA_WIDTH;
        end
        for (int k = 0; k < PARITY_BITS; k++) begin
            if (pos == (1 << k)) begin
                return DATA_WIDTH + 1 + k;
            end
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (DATA_POS[i] == pos) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    // Second bit of a double-bit injection wraps around the word.
    function automatic inj_bit_t inj_partner(input inj_bit_t b);
        if (b == inj_bit_t'(MAX_INJ_BIT)) begin
            return '0;
        end
        return b + inj_bit_t'(1);
    endfunction

endpackage

// File: rtl/ecc_data_encoding_hamming_parity_gen.sv
// Combinational Hamming(38,32) parity plus overall parity.
// Output order is {P32,P16,P8,P4,P2,P1,P0}.
module hamming_parity_gen
    import ecc_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data,
    output logic [PARITY_BITS:0]  parity
);

    logic [PARITY_BITS-1:0] hp;
    logic                   p0;

    always_comb begin
        hp = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            for (int k = 0; k < PARITY_BITS; k++) begin
                if ((DATA_POS[i] & (1 << k)) != 0) begin
                    hp[k] = hp[k] ^ data[i];
                end
            end
        end
    end

    // Overall parity makes the full stored word even.
    assign p0     = (^data) ^ (^hp);
    assign parity = {hp, p0};

endmodule

// File: rtl/ecc_data_encoding.sv
// SECDED write-side encoder: registered output, 2-entry skid buffer,
// one-shot single/double bit error injection and delivered-word counter.
module ecc_data_encoding
    import ecc_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    output logic [MEMORY_DATA_WIDTH-1:0] enc_data_o,
    output logic                         enc_valid_o,
    input  logic                         enc_ready_i,
    input  logic                         inj_sbe_i,
    input  logic                         inj_dbe_i,
    input  logic [INJ_BIT_WIDTH-1:0]     inj_bit_i,
    output logic                         inj_pending_o,
    output logic [COUNT_WIDTH-1:0]       enc_count_o
);

    parity_t   parity;
    mem_word_t enc_word;
    mem_word_t inj_mask;
    mem_word_t store_word;

    slot_t  out_q;
    slot_t  out_d;
    slot_t  skid_q;
    slot_t  skid_d;
    logic   ready_q;
    inj_t   inj_q;
    count_t count_q;

    logic accept;
    logic drain;
    logic arm;

    hamming_parity_gen u_parity (
        .data   (wr_data_i),
        .parity (parity)
    );

    assign enc_word = {parity, wr_data_i};
    assign accept   = wr_valid_i && ready_q;
    assign drain    = !out_q.valid || enc_ready_i;
    assign arm      = (inj_sbe_i || inj_dbe_i)
                   && !inj_q.pending
                   && (int'(inj_bit_i) <= MAX_INJ_BIT);

    always_comb begin
        inj_mask = '0;
        if (inj_q.pending) begin
            inj_mask[inj_q.bit_idx] = 1'b1;
            if (inj_q.mode == INJ_DBE) begin
                inj_mask[inj_partner(inj_q.bit_idx)] = 1'b1;
            end
        end
    end

    assign store_word = enc_word ^ inj_mask;

    // Skid only fills while the output is stalled, so it is never
    // occupied with an empty output and never accepts while full.
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (drain) begin
            if (skid_q.valid) begin
                out_d        = skid_q;
                skid_d.valid = 1'b0;
            end else begin
                out_d.valid = accept;
                if (accept) begin
                    out_d.word = store_word;
                end
            end
        end else if (accept) begin
            skid_d.valid = 1'b1;
            skid_d.word  = store_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= !skid_d.valid;
        end
    end

    // Arming only while idle, so an accept in the arming cycle stays clean.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inj_q <= '{pending: 1'b0, mode: INJ_SBE, bit_idx: '0};
        end else if (accept && inj_q.pending) begin
            inj_q.pending <= 1'b0;
        end else if (arm) begin
            inj_q.pending <= 1'b1;
            inj_q.mode    <= inj_dbe_i ? INJ_DBE : INJ_SBE;
            inj_q.bit_idx <= inj_bit_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (out_q.valid && enc_ready_i && (count_q != '1)) begin
            count_q <= count_q + count_t'(1);
        end
    end

    assign wr_ready_o    = ready_q;
    assign enc_data_o    = out_q.word;
    assign enc_valid_o   = out_q.valid;
    assign inj_pending_o = inj_q.pending;
    assign enc_count_o   = count_q;

endmodule
